afpm_byte_sequencer: RTL and testbench

- Frame controller between the Tiny Tapeout byte pads and the 16-bit logarithmic approximate FP multiplier core.
- Collects two 16-bit operands (A, B) byte-serially, low byte first, one byte of each per cycle.
- Issues a one-cycle start to the core, waits for its done with a timeout guard, then streams the 16-bit result back low byte first.
- One clock domain; owns all operand/result registers so the core can stay purely datapath.

---
 rtl/afpm_byte_sequencer_if.sv | 44 ++++
 rtl/afpm_byte_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_afpm_byte_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/afpm_byte_sequencer_if.sv
// ---------------------------------------------------------------------------
// afpm_byte_sequencer_if
//   Bundles the pad-side byte stream, the multiplier-core handshake and the
//   status flags of afpm_byte_sequencer.
//
//   Pad side   : in_valid, a_byte, b_byte  -> sequencer
//                out_byte, out_valid, out_last <- sequencer
//   Core side  : core_a, core_b, core_start <- sequencer
//                core_done, core_result      -> sequencer
//   Status     : busy, timeout_err, overrun  <- sequencer
//
//   slave  : the sequencer itself.
//   master : whatever drives the pads and models the core (pad ring / bench).
// ---------------------------------------------------------------------------
interface afpm_byte_sequencer_if #(
    parameter int OP_W = 16
);
    logic            in_valid;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [OP_W-1:0] core_a;
    logic [OP_W-1:0] core_b;
    logic            core_start;
    logic            core_done;
    logic [OP_W-1:0] core_result;
    logic [7:0]      out_byte;
    logic            out_valid;
    logic            out_last;
    logic            busy;
    logic            timeout_err;
    logic            overrun;

    modport slave (
        input  in_valid, a_byte, b_byte, core_done, core_result,
        output core_a, core_b, core_start, out_byte, out_valid, out_last,
               busy, timeout_err, overrun
    );

    modport master (
        output in_valid, a_byte, b_byte, core_done, core_result,
        input  core_a, core_b, core_start, out_byte, out_valid, out_last,
               busy, timeout_err, overrun
    );
endinterface

// File: rtl/afpm_byte_sequencer.sv
// ---------------------------------------------------------------------------
// afpm_byte_sequencer
//   Frame controller between the byte-wide pads and the 16-bit logarithmic
//   approximate FP multiplier core. Gathers operands A and B byte-serially
//   (low byte first), pulses core_start, waits for core_done under a timeout
//   guard and streams the result back low byte first. Holds every operand and
//   result register so the core can remain pure datapath.
//
//   Ports
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     ena    : design enable; low freezes all state and masks pulses
//     bus    : afpm_byte_sequencer_if.slave
//              in_valid/a_byte/b_byte  operand bytes in
//              core_a/core_b/core_start operands and start pulse to core
//              core_done/core_result   core completion and product
//              out_byte/out_valid/out_last result byte stream out
//              busy/timeout_err/overrun status flags
// ---------------------------------------------------------------------------
module afpm_byte_sequencer #(
    parameter int              OP_W    = 16,
    parameter int              NBYTES  = OP_W / 8,
    parameter int              TIMEOUT = 15,
    parameter logic [OP_W-1:0] NAN_VAL = OP_W'(16'h7E00)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    afpm_byte_sequencer_if.slave bus
);

    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] LAST_LANE  = CNT_W'(NBYTES - 1);
    // timer counts completed RUN cycles; the cycle that sees this value is
    // the TIMEOUT-th RUN cycle and the last one allowed to wait.
    localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SEND
    } state_t;

    state_t          state_q,       state_d;
    logic [CNT_W-1:0] byte_cnt_q,   byte_cnt_d;
    logic [TMR_W-1:0] timer_q,      timer_d;
    logic [OP_W-1:0]  core_a_q,     core_a_d;
    logic [OP_W-1:0]  core_b_q,     core_b_d;
    logic [OP_W-1:0]  result_q,     result_d;
    logic             start_q,      start_d;
    logic [7:0]       out_byte_q,   out_byte_d;
    logic             timeout_err_q, timeout_err_d;
    logic             overrun_q,    overrun_d;

    logic [7:0]       res_lane;

    // Result byte currently addressed by byte_cnt (meaningful in SEND).
    assign res_lane = result_q[8*byte_cnt_q +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            byte_cnt_q    <= '0;
            timer_q       <= '0;
            core_a_q      <= '0;
            core_b_q      <= '0;
            result_q      <= '0;
            start_q       <= 1'b0;
            out_byte_q    <= '0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else if (ena) begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            timer_q       <= timer_d;
            core_a_q      <= core_a_d;
            core_b_q      <= core_b_d;
            result_q      <= result_d;
            start_q       <= start_d;
            out_byte_q    <= out_byte_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        timer_d       = timer_q;
        core_a_d      = core_a_q;
        core_b_d      = core_b_q;
        result_d      = result_q;
        start_d       = 1'b0;
        out_byte_d    = out_byte_q;
        timeout_err_d = timeout_err_q;
        overrun_d     = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    core_a_d[7:0] = bus.a_byte;
                    core_b_d[7:0] = bus.b_byte;
                    timeout_err_d = 1'b0;
                    timer_d       = '0;
                    if (NBYTES == 1) begin
                        byte_cnt_d = '0;
                        start_d    = 1'b1;
                        state_d    = S_RUN;
                    end else begin
                        byte_cnt_d = CNT_W'(1);
                        state_d    = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (bus.in_valid) begin
                    core_a_d[8*byte_cnt_q +: 8] = bus.a_byte;
                    core_b_d[8*byte_cnt_q +: 8] = bus.b_byte;
                    if (byte_cnt_q == LAST_LANE) begin
                        byte_cnt_d = '0;
                        timer_d    = '0;
                        start_d    = 1'b1;
                        state_d    = S_RUN;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (bus.in_valid) begin
                    overrun_d = 1'b1;
                end
                // core_done is checked first so it wins a coincident timeout.
                if (bus.core_done) begin
                    result_d   = bus.core_result;
                    byte_cnt_d = '0;
                    timer_d    = '0;
                    state_d    = S_SEND;
                end else if (timer_q == TIMER_LAST) begin
                    result_d      = NAN_VAL;
                    timeout_err_d = 1'b1;
                    byte_cnt_d    = '0;
                    timer_d       = '0;
                    state_d       = S_SEND;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_SEND: begin
                if (bus.in_valid) begin
                    overrun_d = 1'b1;
                end
                // Remember the byte just shown so out_byte holds it after SEND.
                out_byte_d = res_lane;
                if (byte_cnt_q == LAST_LANE) begin
                    byte_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pulses are masked by ena so a frozen design never emits a strobe.
    assign bus.core_a      = core_a_q;
    assign bus.core_b      = core_b_q;
    assign bus.core_start  = start_q & ena;
    assign bus.out_valid   = ena & (state_q == S_SEND);
    assign bus.out_last    = ena & (state_q == S_SEND) & (byte_cnt_q == LAST_LANE);
    assign bus.out_byte    = (state_q == S_SEND) ? res_lane : out_byte_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.timeout_err = timeout_err_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_afpm_byte_sequencer.sv
// ---------------------------------------------------------------------------
// tb_afpm_byte_sequencer
//   Directed bench for afpm_byte_sequencer with a small core stub that raises
//   core_done a programmable number of cycles after core_start (or never).
//   Inputs change 1 ns after the rising edge; a negedge monitor records every
//   valid output byte and counts core_start pulses.
// ---------------------------------------------------------------------------
module tb_afpm_byte_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    always #5 clk = ~clk;

    afpm_byte_sequencer_if #(.OP_W(16)) bus ();

    afpm_byte_sequencer #(.OP_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Core stub controls (written only by the main initial block).
    int          stub_delay;
    logic        stub_never;
    logic [15:0] stub_result;
    int          stub_cnt = 0;

    assign bus.core_result = stub_result;

    always @(negedge clk) begin
        bus.core_done = 1'b0;
        if (!rst_n) begin
            stub_cnt = 0;
        end else if (bus.core_start && !stub_never) begin
            if (stub_delay == 0) bus.core_done = 1'b1;
            else stub_cnt = stub_delay;
        end else if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) bus.core_done = 1'b1;
        end
    end

    // Output monitor.
    logic [7:0] obytes[$];
    logic       olast[$];
    int         start_cnt = 0;

    always @(negedge clk) begin
        if (bus.core_start) start_cnt = start_cnt + 1;
        if (bus.out_valid) begin
            obytes.push_back(bus.out_byte);
            olast.push_back(bus.out_last);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input int gap);
        bus.in_valid = 1'b1;
        bus.a_byte   = a[7:0];
        bus.b_byte   = b[7:0];
        tick();
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.a_byte   = a[15:8];
        bus.b_byte   = b[15:8];
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, bus.busy, 1'b0);
    endtask

    task automatic wait_out_valid(input string tag, input int budget);
        int n = 0;
        while (!bus.out_valid && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, bus.out_valid, 1'b1);
    endtask

    task automatic check_bytes(input string tag, input int base, input logic [15:0] res);
        check_eq({tag, "_cnt"},   obytes.size() - base, 2);
        if (obytes.size() >= base + 2) begin
            check_eq({tag, "_b0"},    obytes[base],     res[7:0]);
            check_eq({tag, "_b1"},    obytes[base + 1], res[15:8]);
            check_eq({tag, "_last0"}, olast[base],      1'b0);
            check_eq({tag, "_last1"}, olast[base + 1],  1'b1);
        end
    endtask

    int base;
    int sbase;
    int n;

    initial begin
        rst_n        = 1'b0;
        ena          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a_byte   = 8'h00;
        bus.b_byte   = 8'h00;
        stub_delay   = 3;
        stub_never   = 1'b0;
        stub_result  = 16'h512A;
        repeat (2) tick();

        // Reset state
        check_eq("rst_busy",     bus.busy,        1'b0);
        check_eq("rst_valid",    bus.out_valid,   1'b0);
        check_eq("rst_last",     bus.out_last,    1'b0);
        check_eq("rst_start",    bus.core_start,  1'b0);
        check_eq("rst_core_a",   bus.core_a,      16'h0000);
        check_eq("rst_core_b",   bus.core_b,      16'h0000);
        check_eq("rst_out_byte", bus.out_byte,    8'h00);
        check_eq("rst_tmo",      bus.timeout_err, 1'b0);
        check_eq("rst_ovr",      bus.overrun,     1'b0);
        rst_n = 1'b1;
        tick();

        // Basic frame, core answers 3 cycles after start
        base  = obytes.size();
        sbase = start_cnt;
        send_frame(16'h44DF, 16'h483D, 0);
        check_eq("s1_core_a", bus.core_a,     16'h44DF);
        check_eq("s1_core_b", bus.core_b,     16'h483D);
        check_eq("s1_start",  bus.core_start, 1'b1);
        check_eq("s1_busy",   bus.busy,       1'b1);
        tick();
        check_eq("s1_start_drop", bus.core_start, 1'b0);
        wait_idle("s1_idle", 40);
        check_eq("s1_starts", start_cnt - sbase, 1);
        check_bytes("s1", base, 16'h512A);

        // Core never answers: timeout after 15 RUN cycles
        stub_never = 1'b1;
        base = obytes.size();
        send_frame(16'h1234, 16'h5678, 0);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check_eq("s2_run_cycles", n, 15);
        check_eq("s2_b0",    bus.out_byte, 8'h00);
        check_eq("s2_last0", bus.out_last, 1'b0);
        tick();
        check_eq("s2_b1",    bus.out_byte,    8'h7E);
        check_eq("s2_last1", bus.out_last,    1'b1);
        check_eq("s2_tmo",   bus.timeout_err, 1'b1);
        tick();
        check_eq("s2_idle",     bus.busy,        1'b0);
        check_eq("s2_tmo_hold", bus.timeout_err, 1'b1);
        check_eq("s2_hold_byte", bus.out_byte,   8'h7E);

        // Next frame clears timeout_err on its first byte; exact latency with
        // the core answering in the start cycle.
        stub_never  = 1'b0;
        stub_delay  = 0;
        bus.in_valid = 1'b1;
        bus.a_byte   = 8'hDF;
        bus.b_byte   = 8'h3D;
        tick();
        check_eq("s2_tmo_clr", bus.timeout_err, 1'b0);
        bus.a_byte = 8'h44;
        bus.b_byte = 8'h48;
        tick();
        bus.in_valid = 1'b0;
        check_eq("lat_start", bus.core_start, 1'b1);
        check_eq("lat_nv",    bus.out_valid,  1'b0);
        tick();
        check_eq("lat_v0",    bus.out_valid,  1'b1);
        check_eq("lat_b0",    bus.out_byte,   8'h2A);
        check_eq("lat_l0",    bus.out_last,   1'b0);
        tick();
        check_eq("lat_v1",    bus.out_valid,  1'b1);
        check_eq("lat_b1",    bus.out_byte,   8'h51);
        check_eq("lat_l1",    bus.out_last,   1'b1);
        tick();
        check_eq("lat_idle",  bus.busy,       1'b0);
        check_eq("lat_nv2",   bus.out_valid,  1'b0);

        // Gap of 3 idle cycles between operand bytes
        stub_delay = 3;
        base  = obytes.size();
        sbase = start_cnt;
        send_frame(16'h44DF, 16'h483D, 3);
        check_eq("s3_core_a", bus.core_a, 16'h44DF);
        check_eq("s3_core_b", bus.core_b, 16'h483D);
        wait_idle("s3_idle", 40);
        check_eq("s3_starts", start_cnt - sbase, 1);
        check_bytes("s3", base, 16'h512A);

        // in_valid during RUN and SEND, then a back-to-back frame
        base = obytes.size();
        send_frame(16'h44DF, 16'h483D, 0);
        bus.in_valid = 1'b1;
        bus.a_byte   = 8'hFF;
        bus.b_byte   = 8'hFF;
        tick();
        bus.in_valid = 1'b0;
        check_eq("s4_ovr_run", bus.overrun, 1'b1);
        check_eq("s4_core_a",  bus.core_a,  16'h44DF);
        wait_out_valid("s4_send", 40);
        bus.in_valid = 1'b1;
        bus.a_byte   = 8'hFF;
        bus.b_byte   = 8'hEE;
        tick();
        tick();
        // Cycle after out_last: new frame accepted
        stub_result  = 16'h4000;
        bus.a_byte   = 8'h00;
        bus.b_byte   = 8'h00;
        tick();
        bus.a_byte   = 8'h3C;
        bus.b_byte   = 8'h40;
        tick();
        bus.in_valid = 1'b0;
        check_eq("s4_b2b_a", bus.core_a, 16'h3C00);
        check_eq("s4_b2b_b", bus.core_b, 16'h4000);
        wait_idle("s4_idle", 40);
        check_eq("s4_cnt", obytes.size() - base, 4);
        if (obytes.size() >= base + 4) begin
            check_eq("s4_b0", obytes[base],     8'h2A);
            check_eq("s4_b1", obytes[base + 1], 8'h51);
            check_eq("s4_b2", obytes[base + 2], 8'h00);
            check_eq("s4_b3", obytes[base + 3], 8'h40);
        end
        check_eq("s4_ovr_sticky", bus.overrun, 1'b1);

        // Reset in RUN discards the frame
        stub_result = 16'h512A;
        sbase = start_cnt;
        send_frame(16'h44DF, 16'h483D, 0);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("s5_busy",   bus.busy,       1'b0);
        check_eq("s5_ovr",    bus.overrun,    1'b0);
        check_eq("s5_core_a", bus.core_a,     16'h0000);
        check_eq("s5_start",  bus.core_start, 1'b0);
        base = obytes.size();
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check_eq("s5_no_out", obytes.size() - base, 0);
        check_eq("s5_idle",   bus.busy, 1'b0);
        stub_result = 16'h4000;
        sbase = start_cnt;
        send_frame(16'h3C00, 16'h4000, 0);
        wait_idle("s5_idle2", 40);
        check_eq("s5_starts", start_cnt - sbase, 1);
        check_bytes("s5", base, 16'h4000);

        // ena low for 4 cycles after result byte 0
        stub_result = 16'h512A;
        base = obytes.size();
        send_frame(16'h44DF, 16'h483D, 0);
        wait_out_valid("s6_send", 40);
        check_eq("s6_b0", bus.out_byte, 8'h2A);
        tick();
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("s6_gap_valid", bus.out_valid, 1'b0);
            check_eq("s6_gap_last",  bus.out_last,  1'b0);
            tick();
        end
        ena = 1'b1;
        #1;
        check_eq("s6_v1", bus.out_valid, 1'b1);
        check_eq("s6_b1", bus.out_byte,  8'h51);
        check_eq("s6_l1", bus.out_last,  1'b1);
        tick();
        check_eq("s6_idle", bus.busy, 1'b0);
        check_bytes("s6", base, 16'h512A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
